case_sched: RTL and testbench

CASE_SCHED -- requirements
Module: case_sched

---
 rtl/case_sched.sv | 124 ++++++++++++
 tb/tb_case_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/case_sched.sv
// Round-robin scheduler: four requesters share one combinational decoder.
// Each grant takes one ISSUE cycle and then holds the response until it is accepted or times out.
module case_sched #(
  parameter int CODE_W    = 3,
  parameter int STALL_MAX = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            req_a,
  input  logic [4*CODE_W-1:0]   req_b,
  output logic [3:0]            ack,
  output logic                  dec_en,
  output logic                  dec_a,
  output logic [CODE_W-1:0]     dec_b,
  input  logic [CODE_W-1:0]     dec_c,
  input  logic                  dec_d,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_id,
  output logic [CODE_W-1:0]     resp_c,
  output logic                  resp_d,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state;
  logic [1:0]          ptr;
  logic [1:0]          id_q;
  logic [7:0]          stall;

  logic                gnt_vld;
  logic [1:0]          gnt_id;
  logic [1:0]          idx;
  logic                gnt_a;
  logic [CODE_W-1:0]   gnt_b;

  // Search from ptr+1 upward; walking k downward lets the nearest set bit win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 2'd0;
    idx     = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    gnt_a = 1'b0;
    gnt_b = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_id == 2'(i)) begin
        gnt_a = req_a[i];
        gnt_b = req_b[i*CODE_W +: CODE_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 2'd3;
      id_q       <= 2'd0;
      stall      <= 8'd0;
      err        <= 1'b0;
      ack        <= 4'd0;
      resp_valid <= 1'b0;
      resp_id    <= 2'd0;
      resp_c     <= '0;
      resp_d     <= 1'b0;
      busy       <= 1'b0;
      dec_en     <= 1'b0;
      dec_a      <= 1'b0;
      dec_b      <= '0;
    end else begin
      ack <= 4'd0;
      unique case (state)
        IDLE: begin
          // No grant in the ack cycle: the served requester is still dropping its req.
          if (gnt_vld && ack == 4'd0) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            id_q   <= gnt_id;
            dec_en <= 1'b1;
            dec_a  <= gnt_a;
            dec_b  <= gnt_b;
          end
        end
        ISSUE: begin
          state      <= RESP;
          dec_en     <= 1'b0;
          dec_a      <= 1'b0;
          dec_b      <= '0;
          resp_valid <= 1'b1;
          resp_id    <= id_q;
          resp_c     <= dec_c;
          resp_d     <= dec_d;
          stall      <= 8'd0;
        end
        RESP: begin
          if (resp_ready || stall == 8'(STALL_MAX)) begin
            if (resp_ready) ack <= 4'd1 << id_q;
            else            err <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
            ptr        <= id_q;
            stall      <= 8'd0;
            resp_valid <= 1'b0;
            resp_id    <= 2'd0;
            resp_c     <= '0;
            resp_d     <= 1'b0;
          end else begin
            stall <= stall + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_sched.sv
// Directed bench for case_sched: one instance at the default stall limit, one at STALL_MAX=4.
module tb_case_sched;

  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req = '0, req_a = '0;
  logic [4*CW-1:0] req_b = '0;
  logic          resp_ready = 1'b0;
  logic [3:0]    ack;
  logic          dec_en, dec_a, dec_d, resp_valid, resp_d, busy, err;
  logic [CW-1:0] dec_b, dec_c, resp_c;
  logic [1:0]    resp_id;

  logic [3:0]    q_req = '0, q_req_a = '0;
  logic [4*CW-1:0] q_req_b = '0;
  logic          q_ready = 1'b0;
  logic [3:0]    q_ack;
  logic          q_dec_en, q_dec_a, q_dec_d, q_resp_valid, q_resp_d, q_busy, q_err;
  logic [CW-1:0] q_dec_b, q_dec_c, q_resp_c;
  logic [1:0]    q_resp_id;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Decoder model: c = b ^ {a,a,0}, d = a ^ parity(b).
  assign dec_c   = dec_b ^ {dec_a, dec_a, 1'b0};
  assign dec_d   = dec_a ^ (^dec_b);
  assign q_dec_c = q_dec_b ^ {q_dec_a, q_dec_a, 1'b0};
  assign q_dec_d = q_dec_a ^ (^q_dec_b);

  case_sched #(.CODE_W(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .dec_en(dec_en), .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c), .dec_d(dec_d),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_c(resp_c), .resp_d(resp_d), .busy(busy), .err(err));

  case_sched #(.CODE_W(CW), .STALL_MAX(4)) dut4 (
    .clock(clock), .reset(reset), .req(q_req), .req_a(q_req_a), .req_b(q_req_b),
    .ack(q_ack), .dec_en(q_dec_en), .dec_a(q_dec_a), .dec_b(q_dec_b), .dec_c(q_dec_c), .dec_d(q_dec_d),
    .resp_valid(q_resp_valid), .resp_ready(q_ready), .resp_id(q_resp_id),
    .resp_c(q_resp_c), .resp_d(q_resp_d), .busy(q_busy), .err(q_err));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] rr_c [4] = '{3'd0, 3'd7, 3'd2, 3'd5};
  logic       rr_d [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_valid", resp_valid, 0); chk("rst_ack", ack, 0);
    chk("rst_err", err, 0); chk("rst_dec_en", dec_en, 0); chk("rst_dec_b", dec_b, 0);
    reset = 1'b0;

    // Single request
    req = 4'b0001; req_a = 4'b0001; req_b = 12'b000_000_000_101;
    tick();
    chk("s_dec_en", dec_en, 1); chk("s_dec_a", dec_a, 1); chk("s_dec_b", dec_b, 3'b101);
    chk("s_busy", busy, 1); chk("s_valid_issue", resp_valid, 0);
    resp_ready = 1'b1;
    tick();
    chk("s_valid", resp_valid, 1); chk("s_id", resp_id, 0); chk("s_c", resp_c, 3);
    chk("s_d", resp_d, 1); chk("s_dec_en_off", dec_en, 0);
    tick();
    chk("s_ack", ack, 4'b0001); chk("s_valid_off", resp_valid, 0);
    req = 4'b0000;
    tick();
    chk("s_ack_once", ack, 0); chk("s_idle_busy", busy, 0);

    // Round-robin from reset
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; req_a = 4'b1010; req_b = {3'b011, 3'b010, 3'b001, 3'b000};
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rr_dec_en", dec_en, 1);
      tick();
      chk("rr_id", resp_id, rr_id[t]);
      chk("rr_c", resp_c, rr_c[rr_id[t]]);
      chk("rr_d", resp_d, rr_d[rr_id[t]]);
      tick();
      chk("rr_ack", ack, 4'd1 << rr_id[t]);
      tick();
      chk("rr_ack_clr", ack, 0); chk("rr_busy", busy, 0);
    end

    // Backpressure: 10 stalled cycles then accept
    req = 4'b0010; req_a = 4'b0000; req_b = {3'b000, 3'b000, 3'b100, 3'b000};
    resp_ready = 1'b0;
    tick();
    chk("bp_dec_b", dec_b, 3'b100);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", resp_valid, 1); chk("bp_id", resp_id, 1);
      chk("bp_c", resp_c, 4); chk("bp_d", resp_d, 1); chk("bp_ack", ack, 0);
      tick();
    end
    chk("bp_valid11", resp_valid, 1); chk("bp_c11", resp_c, 4);
    resp_ready = 1'b1;
    tick();
    chk("bp_ack", ack, 4'b0010); chk("bp_err", err, 0);
    req = 4'b0000;
    tick();
    chk("bp_ack_once", ack, 0);

    // Operand isolation and req drop after grant
    req = 4'b0100; req_a = 4'b0100; req_b = {3'b000, 3'b111, 3'b000, 3'b000};
    tick();
    req_b = '0; req_a = 4'b0000; req = 4'b0000;
    chk("iso_dec_a", dec_a, 1); chk("iso_dec_b", dec_b, 3'b111);
    tick();
    chk("iso_c", resp_c, 1); chk("iso_d", resp_d, 0); chk("iso_id", resp_id, 2);
    tick();
    chk("iso_ack", ack, 4'b0100);

    // Reset during RESP
    req = 4'b0100; resp_ready = 1'b0;
    tick(); tick(); tick();
    chk("mr_valid", resp_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mr_busy", busy, 0); chk("mr_valid0", resp_valid, 0); chk("mr_ack", ack, 0);
    tick();
    chk("mr_regrant", dec_en, 1);
    tick();
    chk("mr_id", resp_id, 2);
    resp_ready = 1'b1;
    tick();
    chk("mr_ack2", ack, 4'b0100); chk("mr_err", err, 0);
    req = 4'b0000;

    // STALL_MAX=4: accept on the limit cycle wins
    q_req = 4'b0001; q_req_a = 4'b0001; q_req_b = 12'b000_000_000_101;
    tick();
    chk("lim_dec_en", q_dec_en, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lim_valid", q_resp_valid, 1);
      tick();
    end
    chk("lim_valid5", q_resp_valid, 1);
    q_ready = 1'b1;
    tick();
    chk("lim_ack", q_ack, 4'b0001); chk("lim_err", q_err, 0);
    q_ready = 1'b0; q_req = 4'b1111;
    tick();

    // Timeout: dropped after 5 RESP cycles
    tick();
    chk("to_dec_en", q_dec_en, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("to_valid", q_resp_valid, 1); chk("to_id", q_resp_id, 1); chk("to_ack", q_ack, 0);
      tick();
    end
    chk("to_valid0", q_resp_valid, 0); chk("to_err", q_err, 1);
    chk("to_noack", q_ack, 0); chk("to_busy", q_busy, 0);
    tick(); tick();
    chk("to_next_id", q_resp_id, 2); chk("to_err_sticky", q_err, 1);
    q_ready = 1'b1;
    tick();
    chk("to_ack2", q_ack, 4'b0100); chk("to_err_sticky2", q_err, 1);
    q_req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
